// File: rtl/gfx_cmd_pkg.sv
// Shared command-stream definitions: opcodes, header field layout and the
// arbiter state encoding.
package gfx_cmd_pkg;

    localparam logic [7:0] OP_CLEAR         = 8'h01;
    localparam logic [7:0] OP_DRAW_TRIANGLE = 8'h02;
    localparam logic [7:0] OP_SET_COLOR     = 8'h10;
    localparam logic [7:0] OP_SET_VIEWPORT  = 8'h11;

    localparam int HDR_OP_MSB    = 31;
    localparam int HDR_OP_LSB    = 24;
    localparam int HDR_FLAGS_MSB = 23;
    localparam int HDR_FLAGS_LSB = 16;
    localparam int HDR_COUNT_MSB = 15;
    localparam int HDR_COUNT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN
    } arb_state_t;

    function automatic logic [15:0] hdr_count(input logic [31:0] hdr);
        return hdr[HDR_COUNT_MSB:HDR_COUNT_LSB];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first requester at or after ptr wins,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic [W-1:0] idx;

    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        // Scan from the farthest candidate down so the closest one to ptr wins last.
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC command streams; oversize
// packets are drained upstream and never reach the command processor.
module cmd_stream_arbiter
    import gfx_cmd_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int MAX_PAYLOAD = 16,
    localparam int GW = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC-1:0][31:0] src_data,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     cmd_valid,
    output logic [31:0]              cmd_data,
    input  logic                     cmd_ready,
    output logic [GW-1:0]            grant,
    output logic                     grant_active,
    output logic                     err_oversize
);

    localparam logic [16:0] MAX_LIM = 17'(MAX_PAYLOAD);

    arb_state_t    state_reg;
    logic [GW-1:0] grant_reg;
    logic [GW-1:0] last_grant_reg;
    logic [15:0]   remaining_reg;
    logic          err_reg;

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          sel_valid;
    logic [31:0]   sel_data;
    logic [15:0]   sel_count;
    logic          hdr_oversize;
    logic          xfer;

    assign rr_ptr = (last_grant_reg == GW'(NUM_SRC - 1)) ? '0 : last_grant_reg + 1'b1;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    assign sel_valid    = src_valid[grant_reg];
    assign sel_data     = src_data[grant_reg];
    assign sel_count    = hdr_count(sel_data);
    assign hdr_oversize = {1'b0, sel_count} > MAX_LIM;
    assign xfer         = sel_valid & src_ready[grant_reg];

    always_comb begin
        cmd_valid = 1'b0;
        cmd_data  = '0;
        src_ready = '0;
        case (state_reg)
            ST_HDR: begin
                if (hdr_oversize) begin
                    src_ready[grant_reg] = 1'b1;
                end else begin
                    cmd_valid            = sel_valid;
                    cmd_data             = sel_data;
                    src_ready[grant_reg] = cmd_ready;
                end
            end
            ST_PAYLOAD: begin
                cmd_valid            = sel_valid;
                cmd_data             = sel_data;
                src_ready[grant_reg] = cmd_ready;
            end
            // Draining discards words regardless of the downstream ready.
            ST_DRAIN: src_ready[grant_reg] = sel_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_SRC - 1);
            remaining_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_reg <= pick_idx;
                        state_reg <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        remaining_reg  <= sel_count;
                        last_grant_reg <= grant_reg;
                        if (hdr_oversize) begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_DRAIN;
                        end else if (sel_count == 16'd0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD, ST_DRAIN: begin
                    if (xfer && remaining_reg != 16'd0) begin
                        remaining_reg <= remaining_reg - 16'd1;
                        if (remaining_reg == 16'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign grant        = grant_reg;
    assign grant_active = (state_reg != ST_IDLE);
    assign err_oversize = err_reg;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Bench for cmd_stream_arbiter: per-source word queues, a packet-level
// round-robin reference model, directed scenarios and a randomized run.
module tb_cmd_stream_arbiter;
    import gfx_cmd_pkg::*;

    localparam int NS    = 3;
    localparam int MAXP  = 16;
    localparam int GW    = $clog2(NS);
    localparam int DEPTH = 1024;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NS-1:0]       src_valid;
    logic [NS-1:0][31:0] src_data;
    logic [NS-1:0]       src_ready;
    logic                cmd_valid;
    logic [31:0]         cmd_data;
    logic                cmd_ready;
    logic [GW-1:0]       grant;
    logic                grant_active;
    logic                err_oversize;

    cmd_stream_arbiter #(.NUM_SRC(NS), .MAX_PAYLOAD(MAXP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .grant        (grant),
        .grant_active (grant_active),
        .err_oversize (err_oversize)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [NS][DEPTH];
    int          wr_ptr [NS];
    int          rd_ptr [NS];

    logic [31:0] exp_data [$];
    int          exp_src  [$];
    int          exp_err;
    int          model_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int s, input logic [31:0] w);
        mem[s][wr_ptr[s]] = w;
        wr_ptr[s]++;
    endtask

    task automatic push_pkt(input int s, input logic [31:0] hdr);
        push_word(s, hdr);
        for (int i = 0; i < int'(hdr[15:0]); i++) push_word(s, $urandom);
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < NS; s++) begin
            if (rd_ptr[s] < wr_ptr[s]) begin
                src_valid[s] = 1'b1;
                src_data[s]  = mem[s][rd_ptr[s]];
            end else begin
                src_valid[s] = 1'b0;
                src_data[s]  = '0;
            end
        end
    endtask

    // Packet-level model: whole packets in round-robin order from the source
    // after the last one served; oversize packets vanish and count one error.
    task automatic build_expected();
        int rd [NS];
        int s, cnt;
        bit pending;
        exp_err = 0;
        for (int k = 0; k < NS; k++) rd[k] = rd_ptr[k];
        forever begin
            pending = 0;
            s = 0;
            for (int k = 0; k < NS; k++) begin
                int c = (model_last + 1 + k) % NS;
                if (!pending && rd[c] < wr_ptr[c]) begin
                    pending = 1;
                    s = c;
                end
            end
            if (!pending) break;
            cnt = int'(mem[s][rd[s]][15:0]);
            if (cnt > MAXP) begin
                exp_err++;
            end else begin
                for (int i = 0; i <= cnt; i++) begin
                    exp_data.push_back(mem[s][rd[s] + i]);
                    exp_src.push_back(s);
                end
            end
            rd[s] += cnt + 1;
            model_last = s;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_ready = 1'b0;
        for (int s = 0; s < NS; s++) begin
            wr_ptr[s] = 0;
            rd_ptr[s] = 0;
        end
        drive_inputs();
        exp_data.delete();
        exp_src.delete();
        model_last = NS - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ready_mode: 0 always ready, 1 toggle every cycle, 2 random.
    task automatic run_phase(input string name, input int ready_mode, input int stop_after);
        int          fwd = 0;
        int          errs = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic [NS-1:0] pops;
        logic [NS-1:0] gmask;
        bit          all_empty;
        $display("phase %s", name);
        build_expected();
        drive_inputs();
        cmd_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 32'(cmd_valid), 32'd1);
                check("stall_data", cmd_data, prev_data);
            end
            gmask = '0;
            gmask[grant] = 1'b1;
            check("rdy_ungranted", 32'(src_ready & ~gmask), 32'd0);
            if (cmd_valid) check("rdy_mirror", 32'(src_ready[grant]), 32'(cmd_ready));
            if (err_oversize) errs++;
            if (cmd_valid && cmd_ready) begin
                if (exp_data.size() == 0) begin
                    check("extra_word", cmd_data, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] e  = exp_data.pop_front();
                    int          es = exp_src.pop_front();
                    $display("xfer src=%0d data=%h", grant, cmd_data);
                    check("data", cmd_data, e);
                    check("grant", 32'(grant), 32'(es));
                end
                fwd++;
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_data  = cmd_data;
            pops = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) if (pops[s]) rd_ptr[s]++;
            drive_inputs();
            case (ready_mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = ~cmd_ready;
                default: cmd_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            if (stop_after > 0 && fwd >= stop_after) break;
            all_empty = 1;
            for (int s = 0; s < NS; s++) if (rd_ptr[s] < wr_ptr[s]) all_empty = 0;
            if (all_empty && exp_data.size() == 0 && !grant_active) break;
            if (cyc > 4000) begin
                check("timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        if (stop_after == 0) begin
            check("err_count", 32'(errs), 32'(exp_err));
            check("words_left", 32'(exp_data.size()), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_cmd_data"}, cmd_data, 32'd0);
        check({tag, "_src_ready"}, 32'(src_ready), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_active"}, 32'(grant_active), 32'd0);
        check({tag, "_err"}, 32'(err_oversize), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_ready = 1'b0;
        src_valid = '0;
        src_data  = '0;
        do_reset();
        check_reset_outputs("reset");

        // Single-source SET_VIEWPORT packet.
        push_word(0, 32'h1100_0004);
        push_word(0, 32'd0);
        push_word(0, 32'd0);
        push_word(0, 32'd4);
        push_word(0, 32'd3);
        run_phase("single", 0, 0);

        // Simultaneous requests: src0 triangle must complete before src1 clear.
        do_reset();
        push_word(0, 32'h0200_0006);
        push_word(0, 32'd10);
        push_word(0, 32'd10);
        push_word(0, 32'd50);
        push_word(0, 32'd10);
        push_word(0, 32'd30);
        push_word(0, 32'd40);
        push_word(1, 32'h0100_0000);
        run_phase("simultaneous", 0, 0);

        // Fairness: two continuously requesting sources alternate.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            push_word(0, 32'h1000_0001);
            push_word(0, 32'h00FF_0000);
            push_word(1, 32'h1000_0001);
            push_word(1, 32'h00FF_0000);
        end
        run_phase("fairness", 0, 0);

        // Backpressure: ready toggles every cycle during a triangle.
        do_reset();
        push_pkt(0, 32'h0200_0006);
        run_phase("backpressure", 1, 0);

        // Oversize drop from src1, then a CLEAR from src0 is still forwarded.
        do_reset();
        push_pkt(1, 32'h0200_0020);
        run_phase("oversize", 2, 0);
        check("oversize_consumed", 32'(rd_ptr[1]), 32'd33);
        push_word(0, 32'h0100_0000);
        run_phase("after_oversize", 0, 0);

        // Reset mid-packet after the header and two payload words.
        do_reset();
        push_pkt(0, 32'h0200_0006);
        push_pkt(1, 32'h0100_0000);
        run_phase("mid_packet", 0, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        do_reset();
        push_pkt(1, 32'h1000_0001);
        push_pkt(0, 32'h1000_0001);
        run_phase("post_reset", 0, 0);

        // Randomized packets, occasional oversize, random downstream ready.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NS; s++) begin
                int np = $urandom_range(1, 4);
                for (int p = 0; p < np; p++) begin
                    logic [31:0] hdr = $urandom;
                    hdr[15:0] = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(MAXP + 1, MAXP + 8))
                                                           : 16'($urandom_range(0, MAXP));
                    push_pkt(s, hdr);
                end
            end
            run_phase("random", 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_stream_arbiter.md
# cmd_stream_arbiter

Packet-atomic round-robin arbiter that merges `NUM_SRC` command-word streams into the single `cmd_valid/cmd_data/cmd_ready` input of `command_processor`. It sits directly upstream of `command_processor`, with inputs such as the host MMIO FIFO and the DMA command fetcher. It parses each header word, locks the grant for the header plus its payload words, and drops packets whose payload count exceeds `MAX_PAYLOAD`. This keeps one requester from interleaving words into another's packet.

## Interface
- `NUM_SRC`, 2: number of requesting command streams (2..8).
- `MAX_PAYLOAD`, 16: largest legal payload count. Larger packets are discarded.
- `clk`  in  1: single clock. All logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `src_valid`  in  NUM_SRC: per-source word valid.
- `src_data`  in  NUM_SRC×32: per-source word, packed `[NUM_SRC-1:0][31:0]`.
- `src_ready`  out  NUM_SRC: per-source accept, one-hot or zero.
- `cmd_valid`  out  1: word valid toward `command_processor`.
- `cmd_data`  out  32: forwarded word.
- `cmd_ready`  in  1: `command_processor` accept.
- `grant`  out  $clog2(NUM_SRC): currently locked source.
- `grant_active`  out  1: a source is locked (state ≠ ST_IDLE).
- `err_oversize`  out  1: one-cycle pulse when an oversize header is consumed.

## Operation
- Header word layout:
  - opcode `[31:24]`
  - flags `[23:16]`
  - payload count `[15:0]`
- **Handshake.** A transfer occurs on a cycle where valid && ready. Valid and data from a source stay stable until accepted. This block guarantees the same for `cmd_valid/cmd_data`.
- **ST_IDLE**
  - Drives `cmd_valid=0` and `src_ready=0`.
  - If any `src_valid` is set, pick the winner by round-robin, register it in `grant`, and go to ST_HDR.
  - Round-robin search starts at `(last_grant+1) mod NUM_SRC`.
- **ST_HDR**
  - Legal header (count ≤ MAX_PAYLOAD):
    - Pass through combinationally: `cmd_valid=src_valid[grant]`, `cmd_data=src_data[grant]`, `src_ready[grant]=cmd_ready`.
    - On handshake, load `remaining ← count` and set `last_grant ← grant`.
    - If count=0, go to ST_IDLE. Otherwise go to ST_PAYLOAD.
  - Oversize header (count > MAX_PAYLOAD):
    - Drive `cmd_valid=0` and `src_ready[grant]=1`.
    - On consume, pulse `err_oversize`, load `remaining ← count`, set `last_grant ← grant`, and go to ST_DRAIN.
- **ST_PAYLOAD**
  - Same pass-through as ST_HDR. Each handshake decrements `remaining`.
  - The handshake with `remaining==1` returns to ST_IDLE.
- **ST_DRAIN**
  - Drive `cmd_valid=0` and `src_ready[grant]=src_valid[grant]`. Discard each consumed word and decrement `remaining`.
  - The word with `remaining==1` returns to ST_IDLE.
- Non-granted sources always see `src_ready=0`.
- Opcodes are not decoded; any opcode is forwarded. Flags are forwarded unchanged.
- `remaining` is 16-bit unsigned. It is never decremented at 0, so no wrap.

## Timing
- **Reset values:**
  - `cmd_valid=0`, `src_ready=0`, `cmd_data=0` (qualified by valid), `err_oversize=0`
  - `grant=0`, `grant_active=0`, state ST_IDLE
  - `last_grant=NUM_SRC-1`, so source 0 wins first.
- **Latency and throughput:**
  - One cycle from first `src_valid` in ST_IDLE to header presented in ST_HDR.
  - Zero-cycle combinational path `src_valid→cmd_valid` and `cmd_ready→src_ready` while locked.
  - One idle bubble per packet boundary. Within a packet, one word per cycle at full rate.
- **Boundary cases:**
  - Simultaneous requests in ST_IDLE: resolved by round-robin only. A packet is never interrupted.
  - A source dropping `src_valid` mid-packet (protocol gap): the grant is held and the block waits indefinitely.
  - `cmd_ready` low in ST_DRAIN: ignored. Draining never blocks on `cmd_ready`.
  - `rst_n` asserted mid-packet: immediately return to reset values. The partial packet is abandoned, and upstream sources share the same reset.
- `err_oversize` is exactly one cycle per oversize header.

## Structure
- Shared package `gfx_cmd_pkg`:
  - opcode constants: `OP_CLEAR=8'h01`, `OP_DRAW_TRIANGLE=8'h02`, `OP_SET_COLOR=8'h10`, `OP_SET_VIEWPORT=8'h11`
  - header field slice localparams
  - `hdr_count()` function
  - state enum `arb_state_t`: ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DRAIN
- Sub-module `rr_pick`: combinational round-robin select.
  - Inputs: request vector and pointer.
  - Outputs: winner index and any-request flag.

## Test plan
- **Single-source packet:** src0 sends 0x11000004, 0,0,4,3 with `cmd_ready=1`.
  - Exactly 5 words appear on `cmd_data` in order, `grant=0` throughout, then ST_IDLE.
- **Simultaneous requests:** after reset, src0 sends 0x02000006 + 10,10,50,10,30,40 while src1 holds 0x01000000.
  - All 7 src0 words are forwarded first, then src1's header. No interleave.
- **Round-robin fairness:** both sources continuously offer 0x10000001, 0x00FF0000.
  - Grants alternate 0,1,0,1 over 4 packets.
- **Backpressure:** `cmd_ready` toggles every cycle during a triangle packet.
  - `cmd_data` is stable while valid && !ready, 7 words arrive unaltered, and `src_ready[0]` mirrors `cmd_ready`.
- **Oversize drop:** src1 sends 0x02000020 + 32 words, then src0 sends 0x01000000.
  - No src1 word reaches `cmd_valid`, `err_oversize` pulses once, and all 32 words are consumed.
  - src0's CLEAR is then forwarded.
- **Reset mid-packet:** `rst_n` is pulled low after 2 of 6 triangle payloads.
  - All outputs go to reset values.
  - The next request from both sources is granted to src0.
